// File: rtl/mainfsm_if.sv
// Control bundle between the multicycle main FSM (master) and the datapath (slave).
// ALUOP_W must match the ALUOP_W of the mainfsm instance bound to it.
interface mainfsm_if #(
    parameter int ALUOP_W = 2
) ();
    logic [5:0]         op;
    logic               mem_ready;
    logic               pcwrite;
    logic               irwrite;
    logic               regwrite;
    logic               memwrite;
    logic               iord;
    logic               alusrca;
    logic               regdst;
    logic               memtoreg;
    logic               branch;
    logic               branch_ne;
    logic               zeroext;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;
    logic [3:0]         state;

    modport master (
        input  op, mem_ready,
        output pcwrite, irwrite, regwrite, memwrite,
        output iord, alusrca, regdst, memtoreg,
        output branch, branch_ne, zeroext,
        output alusrcb, pcsrc, aluop, illegal, state
    );

    modport slave (
        output op, mem_ready,
        input  pcwrite, irwrite, regwrite, memwrite,
        input  iord, alusrca, regdst, memtoreg,
        input  branch, branch_ne, zeroext,
        input  alusrcb, pcsrc, aluop, illegal, state
    );
endinterface

// File: rtl/mainfsm.sv
// Main control FSM of a multicycle MIPS-style processor (lw/sw/R-type/beq/bne/addi/ori/j).
// Moore outputs decoded from the state register; FETCH/MEMRD/MEMWR stall on mem_ready.
module mainfsm #(
    parameter int ALUOP_W    = 2,
    parameter bit ENABLE_BNE = 1'b1,
    parameter bit ENABLE_ORI = 1'b1
) (
    input  logic      clk,
    input  logic      reset_n,
    mainfsm_if.master bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    typedef struct packed {
        logic       pcwrite;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       iord;
        logic       alusrca;
        logic       regdst;
        logic       memtoreg;
        logic       branch;
        logic       branch_ne;
        logic       zeroext;
        logic       illegal;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_s;
    ctrl_t  ctrl_o;

    function automatic logic is_ori(input logic [5:0] op_i);
        return ENABLE_ORI && (op_i == OP_ORI);
    endfunction

    // State register; reset lands in FETCH without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_d = S_FETCH;
        ctrl_s  = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_s.alusrcb = 2'b01;
                ctrl_s.irwrite = bus.mem_ready;
                ctrl_s.pcwrite = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                ctrl_s.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_IMMEX;
                    OP_J:         state_d = S_JUMP;
                    OP_BNE: begin
                        if (ENABLE_BNE) begin
                            state_d = S_BRANCH;
                        end else begin
                            ctrl_s.illegal = 1'b1;
                            state_d        = S_FETCH;
                        end
                    end
                    OP_ORI: begin
                        if (ENABLE_ORI) begin
                            state_d = S_IMMEX;
                        end else begin
                            ctrl_s.illegal = 1'b1;
                            state_d        = S_FETCH;
                        end
                    end
                    default: begin
                        ctrl_s.illegal = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.alusrcb = 2'b10;
                if (bus.op == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                ctrl_s.iord = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                ctrl_s.memtoreg = 1'b1;
                ctrl_s.regwrite = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                // memwrite is held through the whole stall so the memory sees a stable request.
                ctrl_s.iord     = 1'b1;
                ctrl_s.memwrite = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXECUTE: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.aluop   = 2'b10;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_s.regdst   = 1'b1;
                ctrl_s.regwrite = 1'b1;
                state_d         = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_s.alusrca   = 1'b1;
                ctrl_s.aluop     = 2'b01;
                ctrl_s.pcsrc     = 2'b01;
                ctrl_s.branch    = (bus.op == OP_BEQ);
                ctrl_s.branch_ne = (bus.op == OP_BNE);
                state_d          = S_FETCH;
            end
            S_IMMEX: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.alusrcb = 2'b10;
                if (is_ori(bus.op)) begin
                    ctrl_s.aluop   = 2'b11;
                    ctrl_s.zeroext = 1'b1;
                end else begin
                    ctrl_s.aluop   = 2'b00;
                    ctrl_s.zeroext = 1'b0;
                end
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                ctrl_s.regwrite = 1'b1;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                ctrl_s.pcsrc   = 2'b10;
                ctrl_s.pcwrite = 1'b1;
                state_d        = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // While reset is held, FETCH's mem_ready-driven strobes must not leak out.
    always_comb begin
        if (reset_n) begin
            ctrl_o = ctrl_s;
        end else begin
            ctrl_o = '0;
        end
    end

    assign bus.pcwrite   = ctrl_o.pcwrite;
    assign bus.irwrite   = ctrl_o.irwrite;
    assign bus.regwrite  = ctrl_o.regwrite;
    assign bus.memwrite  = ctrl_o.memwrite;
    assign bus.iord      = ctrl_o.iord;
    assign bus.alusrca   = ctrl_o.alusrca;
    assign bus.regdst    = ctrl_o.regdst;
    assign bus.memtoreg  = ctrl_o.memtoreg;
    assign bus.branch    = ctrl_o.branch;
    assign bus.branch_ne = ctrl_o.branch_ne;
    assign bus.zeroext   = ctrl_o.zeroext;
    assign bus.illegal   = ctrl_o.illegal;
    assign bus.alusrcb   = ctrl_o.alusrcb;
    assign bus.pcsrc     = ctrl_o.pcsrc;
    assign bus.aluop     = ALUOP_W'(ctrl_o.aluop);
    assign bus.state     = state_q;

endmodule

// File: tb/tb_mainfsm.sv
// Directed bench for mainfsm: default build (u0) and a 3-bit aluop build without bne (u1).
module tb_mainfsm;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    mainfsm_if #(.ALUOP_W(2)) if0 ();
    mainfsm_if #(.ALUOP_W(3)) if1 ();

    mainfsm #(.ALUOP_W(2), .ENABLE_BNE(1'b1), .ENABLE_ORI(1'b1)) u0 (
        .clk(clk), .reset_n(reset_n), .bus(if0.master));
    mainfsm #(.ALUOP_W(3), .ENABLE_BNE(1'b0), .ENABLE_ORI(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] o, input logic mr);
        if0.op = o;  if0.mem_ready = mr;
        if1.op = o;  if1.mem_ready = mr;
    endtask

    task automatic park();
        drive(if0.op, 1'b0);
        @(posedge clk); #1;
    endtask

    function automatic logic [21:0] out0();
        return {if0.pcwrite, if0.irwrite, if0.regwrite, if0.memwrite, if0.iord, if0.alusrca,
                if0.regdst, if0.memtoreg, if0.branch, if0.branch_ne, if0.zeroext, if0.illegal,
                if0.alusrcb, if0.pcsrc, if0.aluop, if0.state};
    endfunction

    function automatic logic [22:0] out1();
        return {if1.pcwrite, if1.irwrite, if1.regwrite, if1.memwrite, if1.iord, if1.alusrca,
                if1.regdst, if1.memtoreg, if1.branch, if1.branch_ne, if1.zeroext, if1.illegal,
                if1.alusrcb, if1.pcsrc, if1.aluop, if1.state};
    endfunction

    task automatic test_reset();
        #2;
        vectors++; if (out0() !== 22'd0) begin miscompares++; $display("FAIL reset_outs_u0: got %h expected 0", out0()); end
        vectors++; if (out1() !== 23'd0) begin miscompares++; $display("FAIL reset_outs_u1: got %h expected 0", out1()); end
        @(posedge clk); #1;
        vectors++; if ({if0.irwrite, if0.pcwrite, if0.state} !== 6'd0) begin miscompares++; $display("FAIL reset_hold: got %b expected 0", {if0.irwrite, if0.pcwrite, if0.state}); end
        reset_n = 1'b1;
        @(negedge clk);
        vectors++; if ({if0.irwrite, if0.pcwrite, if0.state} !== 6'b110000) begin miscompares++; $display("FAIL release_fetch: got %b expected 110000", {if0.irwrite, if0.pcwrite, if0.state}); end
        drive(6'd0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_stall();
        drive(6'b111111, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++; if ({if0.irwrite, if0.pcwrite, if0.state} !== 6'd0) begin miscompares++; $display("FAIL fetch_stall: got %b expected 000000", {if0.irwrite, if0.pcwrite, if0.state}); end
            @(posedge clk); #1;
        end
        drive(6'b111111, 1'b1);
        @(negedge clk);
        vectors++; if ({if0.irwrite, if0.pcwrite} !== 2'b11) begin miscompares++; $display("FAIL fetch_ready: got %b expected 11", {if0.irwrite, if0.pcwrite}); end
        @(posedge clk); #1;
        drive(6'b111111, 1'b0);
        @(negedge clk);
        vectors++; if (if0.state !== 4'd1) begin miscompares++; $display("FAIL fetch_to_decode: got %0d expected 1", if0.state); end
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        logic [3:0] st_e [6];
        st_e = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        drive(6'b100011, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++; if (if0.state !== st_e[i]) begin miscompares++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, if0.state, st_e[i]); end
            vectors++; if ({if0.regwrite, if0.memtoreg} !== ((st_e[i] == 4'd4) ? 2'b11 : 2'b00)) begin miscompares++; $display("FAIL lw_wb[%0d]: got %b", i, {if0.regwrite, if0.memtoreg}); end
            if (st_e[i] == 4'd3) begin
                vectors++; if (if0.iord !== 1'b1) begin miscompares++; $display("FAIL lw_iord: got %b expected 1", if0.iord); end
            end
            if (i < 5) begin @(posedge clk); #1; end
        end
        park();
    endtask

    task automatic test_sw();
        logic       mr_t [8];
        logic [3:0] st_e [8];
        int         mw_cnt;
        mr_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        st_e = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
        mw_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(6'b101011, mr_t[i]);
            @(negedge clk);
            vectors++; if (if0.state !== st_e[i]) begin miscompares++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, if0.state, st_e[i]); end
            vectors++; if ({if0.memwrite, if0.iord, if0.regwrite} !== ((st_e[i] == 4'd5) ? 3'b110 : 3'b000)) begin miscompares++; $display("FAIL sw_strobe[%0d]: got %b", i, {if0.memwrite, if0.iord, if0.regwrite}); end
            if (if0.memwrite === 1'b1) mw_cnt++;
            @(posedge clk); #1;
        end
        vectors++; if (mw_cnt != 4) begin miscompares++; $display("FAIL sw_memwrite_cycles: got %0d expected 4", mw_cnt); end
    endtask

    task automatic test_rtype();
        logic [3:0] st_e [5];
        st_e = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        drive(6'b000000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (if0.state !== st_e[i]) begin miscompares++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, if0.state, st_e[i]); end
            if (i == 2) begin
                vectors++; if ({if0.alusrca, if0.alusrcb, if0.aluop} !== 5'b10010) begin miscompares++; $display("FAIL rtype_exec: got %b expected 10010", {if0.alusrca, if0.alusrcb, if0.aluop}); end
                vectors++; if (if1.aluop !== 3'b010) begin miscompares++; $display("FAIL rtype_aluop_w3: got %b expected 010", if1.aluop); end
            end
            if (i == 3) begin
                vectors++; if ({if0.regwrite, if0.regdst, if0.memtoreg} !== 3'b110) begin miscompares++; $display("FAIL rtype_wb: got %b expected 110", {if0.regwrite, if0.regdst, if0.memtoreg}); end
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
        park();
    endtask

    task automatic test_imm(input logic [5:0] o, input logic [1:0] alu_e, input logic [2:0] alu1_e, input logic zx_e);
        logic [3:0] st_e [5];
        st_e = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
        drive(o, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (if0.state !== st_e[i]) begin miscompares++; $display("FAIL imm_state[%0d]: got %0d expected %0d", i, if0.state, st_e[i]); end
            if (i == 2) begin
                vectors++; if ({if0.alusrca, if0.alusrcb, if0.aluop, if0.zeroext} !== {3'b110, alu_e, zx_e}) begin miscompares++; $display("FAIL imm_ex: got %b expected %b", {if0.alusrca, if0.alusrcb, if0.aluop, if0.zeroext}, {3'b110, alu_e, zx_e}); end
                vectors++; if ({if1.aluop, if1.zeroext} !== {alu1_e, zx_e}) begin miscompares++; $display("FAIL imm_ex_w3: got %b expected %b", {if1.aluop, if1.zeroext}, {alu1_e, zx_e}); end
            end
            if (i == 3) begin
                vectors++; if ({if1.regwrite, if1.regdst, if1.memtoreg} !== 3'b100) begin miscompares++; $display("FAIL imm_wb: got %b expected 100", {if1.regwrite, if1.regdst, if1.memtoreg}); end
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
        park();
    endtask

    task automatic test_branch();
        logic [3:0] st_e [4];
        st_e = '{4'd0, 4'd1, 4'd8, 4'd0};
        drive(6'b000100, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; if (if0.state !== st_e[i]) begin miscompares++; $display("FAIL beq_state[%0d]: got %0d expected %0d", i, if0.state, st_e[i]); end
            if (i == 2) begin
                vectors++; if ({if0.branch, if0.branch_ne, if0.pcsrc, if0.aluop, if0.alusrca, if0.pcwrite} !== 8'b10010110) begin miscompares++; $display("FAIL beq_ctrl: got %b expected 10010110", {if0.branch, if0.branch_ne, if0.pcsrc, if0.aluop, if0.alusrca, if0.pcwrite}); end
            end
            if (i < 3) begin @(posedge clk); #1; end
        end
        park();
    endtask

    task automatic test_bne();
        logic       mr_t [4];
        logic [3:0] st0_e [4];
        logic [3:0] st1_e [4];
        mr_t  = '{1'b1, 1'b1, 1'b0, 1'b0};
        st0_e = '{4'd0, 4'd1, 4'd8, 4'd0};
        st1_e = '{4'd0, 4'd1, 4'd0, 4'd0};
        for (int i = 0; i < 4; i++) begin
            drive(6'b000101, mr_t[i]);
            @(negedge clk);
            vectors++; if (if0.state !== st0_e[i]) begin miscompares++; $display("FAIL bne_state_u0[%0d]: got %0d expected %0d", i, if0.state, st0_e[i]); end
            vectors++; if (if1.state !== st1_e[i]) begin miscompares++; $display("FAIL bne_state_u1[%0d]: got %0d expected %0d", i, if1.state, st1_e[i]); end
            vectors++; if (if1.illegal !== (i == 1)) begin miscompares++; $display("FAIL bne_illegal_u1[%0d]: got %b", i, if1.illegal); end
            if (i == 2) begin
                vectors++; if ({if0.branch, if0.branch_ne, if0.pcsrc} !== 4'b0101) begin miscompares++; $display("FAIL bne_ctrl: got %b expected 0101", {if0.branch, if0.branch_ne, if0.pcsrc}); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump();
        logic [3:0] st_e [4];
        st_e = '{4'd0, 4'd1, 4'd11, 4'd0};
        drive(6'b000010, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; if (if0.state !== st_e[i]) begin miscompares++; $display("FAIL j_state[%0d]: got %0d expected %0d", i, if0.state, st_e[i]); end
            if (i == 2) begin
                vectors++; if ({if0.pcwrite, if0.pcsrc, if0.irwrite} !== 4'b1100) begin miscompares++; $display("FAIL j_ctrl: got %b expected 1100", {if0.pcwrite, if0.pcsrc, if0.irwrite}); end
            end
            if (i < 3) begin @(posedge clk); #1; end
        end
        park();
    endtask

    task automatic test_illegal();
        drive(6'b111111, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if ({if0.illegal, if0.state} !== 5'b10001) begin miscompares++; $display("FAIL ill_pulse: got %b expected 10001", {if0.illegal, if0.state}); end
        vectors++; if ({if0.pcwrite, if0.irwrite, if0.regwrite, if0.memwrite} !== 4'b0000) begin miscompares++; $display("FAIL ill_strobes: got %b expected 0000", {if0.pcwrite, if0.irwrite, if0.regwrite, if0.memwrite}); end
        @(posedge clk); #1;
        drive(6'b111111, 1'b0);
        @(negedge clk);
        vectors++; if ({if0.illegal, if0.state} !== 5'b00000) begin miscompares++; $display("FAIL ill_after: got %b expected 00000", {if0.illegal, if0.state}); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        drive(6'b000000, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (if0.state !== 4'd6) begin miscompares++; $display("FAIL mid_pre_state: got %0d expected 6", if0.state); end
        #1 reset_n = 1'b0;
        #1;
        vectors++; if (out0() !== 22'd0) begin miscompares++; $display("FAIL mid_reset_u0: got %h expected 0", out0()); end
        vectors++; if (out1() !== 23'd0) begin miscompares++; $display("FAIL mid_reset_u1: got %h expected 0", out1()); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(6'b111111, 1'b1);
        @(negedge clk);
        vectors++; if ({if0.irwrite, if0.pcwrite, if0.state} !== 6'b110000) begin miscompares++; $display("FAIL mid_release: got %b expected 110000", {if0.irwrite, if0.pcwrite, if0.state}); end
        @(posedge clk); #1;
        drive(6'b111111, 1'b0);
        @(negedge clk);
        vectors++; if (if0.state !== 4'd1) begin miscompares++; $display("FAIL mid_resume: got %0d expected 1", if0.state); end
        @(posedge clk); #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        drive(6'd0, 1'b1);
        test_reset();
        test_fetch_stall();
        test_lw();
        test_sw();
        test_rtype();
        test_imm(6'b001000, 2'b00, 3'b000, 1'b0);
        test_imm(6'b001101, 2'b11, 3'b011, 1'b1);
        test_branch();
        test_bne();
        test_jump();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mainfsm.md
MAINFSM -- requirements
Module: mainfsm

Interface
REQ-001 Parameter ALUOP_W, default 2, aluop width; SHALL be >= 2, with codes zero-extended to ALUOP_W.
REQ-002 Parameter ENABLE_BNE, default 1, enables bne (op 000101).
REQ-003 Parameter ENABLE_ORI, default 1, enables ori (op 001101).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 op  in  6  opcode of instruction register contents.
REQ-007 mem_ready  in  1  memory access completes this cycle.
REQ-008 pcwrite, irwrite, regwrite, memwrite  out  1 each  write strobes.
REQ-009 iord, alusrca, regdst, memtoreg  out  1 each  datapath selects.
REQ-010 branch, branch_ne, zeroext  out  1 each  beq enable, bne enable, immediate zero-extend.
REQ-011 alusrcb  out  2; pcsrc  out  2; aluop  out  ALUOP_W.
REQ-012 illegal  out  1  one-cycle pulse on unsupported opcode.
REQ-013 state  out  4  current state encoding, for debug.

Function
REQ-014 Moore FSM; every output SHALL depend only on state, except FETCH/MEMRD/MEMWR strobes, which are gated by mem_ready as below; unlisted outputs SHALL be 0.
REQ-015 Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11; codes 12-15 SHALL go to FETCH.
REQ-016 FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready; stay while mem_ready=0, else DECODE.
REQ-017 DECODE: alusrca=0, alusrcb=11, aluop=00; next: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 000101->BRANCH (ENABLE_BNE), 001000->IMMEX, 001101->IMMEX (ENABLE_ORI), 000010->JUMP.
REQ-018 DECODE with any other (or disabled) opcode SHALL pulse illegal=1 for that cycle and go to FETCH.
REQ-019 MEMADR: alusrca=1, alusrcb=10, aluop=00; op 100011->MEMRD, else MEMWR.
REQ-020 MEMRD: iord=1; stay while mem_ready=0, else MEMWB.
REQ-021 MEMWB: regdst=0, memtoreg=1, regwrite=1; -> FETCH.
REQ-022 MEMWR: iord=1, memwrite=1 held every cycle in state; stay while mem_ready=0, else FETCH.
REQ-023 EXECUTE: alusrca=1, alusrcb=00, aluop=10; -> ALUWB.
REQ-024 ALUWB: regdst=1, memtoreg=0, regwrite=1; -> FETCH.
REQ-025 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01; branch=1 if op=000100, branch_ne=1 if op=000101; -> FETCH.
REQ-026 IMMEX: alusrca=1, alusrcb=10; addi: aluop=00, zeroext=0; ori: aluop=11, zeroext=1; -> IMMWB.
REQ-027 IMMWB: regdst=0, memtoreg=0, regwrite=1; -> FETCH.
REQ-028 JUMP: pcsrc=10, pcwrite=1; -> FETCH.
REQ-029 op SHALL be sampled in DECODE, MEMADR, BRANCH, IMMEX only; it is stable from irwrite until next FETCH.
REQ-030 Cycle counts with mem_ready=1: R-type/addi/ori 4, lw 5, sw 4, beq/bne 3, j 3; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.

Reset
REQ-031 reset_n=0 SHALL force state=FETCH immediately and hold all outputs at 0, including mid-instruction and mid-stall.
REQ-032 After reset_n deasserts, first rising edge SHALL evaluate FETCH normally; no write strobe SHALL assert before it.

Verification
REQ-033 lw, mem_ready=1: states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-034 sw, mem_ready=0 for 3 cycles in MEMWR: memwrite=1, iord=1 for 4 cycles, then state 0.
REQ-035 op=000101, ENABLE_BNE=1 -> BRANCH with branch_ne=1, branch=0; ENABLE_BNE=0 -> illegal pulse, state 0.
REQ-036 ori, ALUOP_W=3: IMMEX aluop=011, zeroext=1; IMMWB regwrite=1, regdst=0.
REQ-037 op=111111 in DECODE: illegal=1 for one cycle, no write strobe, next state 0.
REQ-038 reset_n low during EXECUTE: outputs 0 at once, state=0; after release, FETCH with mem_ready=1 asserts irwrite/pcwrite.
